pipe_hazard_ctrl: RTL and testbench

//   Pipeline sequencer for the RV32I+AES core. Drives the PC enable, the IF/ID enable and flush, and the
//   ID/EX 'start' (0 = bubble into EX). Resolves load-use stalls, branch/jump flushes, ECALL halt and the

---
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard sequencer (slave).
// stall_cycles is present only when PIPE_STALL_CNT_EN is defined.
interface pipe_hazard_ctrl_if;
    logic        start_in;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_br_taken;
    logic        ex_jal;
    logic        ex_jalr;
    logic        ex_ecall;
    logic        ex_enable_aes;
    logic        aes_done;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_start;
    logic        aes_start;
    logic        aes_wb_valid;
    logic        halted;
    logic        aes_err;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
        output start_in, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_br_taken, ex_jal, ex_jalr, ex_ecall, ex_enable_aes, aes_done,
        input  pc_en, if_id_en, if_id_flush, id_ex_start, aes_start, aes_wb_valid, halted,
               aes_err
`ifdef PIPE_STALL_CNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  start_in, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_br_taken, ex_jal, ex_jalr, ex_ecall, ex_enable_aes, aes_done,
        output pc_en, if_id_en, if_id_flush, id_ex_start, aes_start, aes_wb_valid, halted,
               aes_err
`ifdef PIPE_STALL_CNT_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect flushes, ECALL halt and AES wait with timeout.
// Optional PIPE_STALL_CNT_EN adds a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned AES_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int unsigned CntW = $clog2(AES_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRun, StAesWait, StHalt} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic              r_halted;
    logic              r_aes_err;
    logic              w_aes_err_d;

    logic w_redirect;
    logic w_load_use;
    logic w_timeout;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_flush;
    logic w_start;
    logic w_aes_start;
    logic w_wb_valid;

    assign w_redirect = hz.ex_br_taken | hz.ex_jal | hz.ex_jalr;
    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                        ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    assign w_timeout  = (r_cnt == CntW'(AES_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_halted  <= 1'b0;
            r_aes_err <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_halted  <= (w_state_d == StHalt);
            r_aes_err <= w_aes_err_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_aes_err_d = r_aes_err;
        unique case (r_state)
            StIdle: begin
                if (hz.start_in) w_state_d = StRun;
            end
            StRun: begin
                if (w_redirect) begin
                    w_state_d = StRun;
                end else if (hz.ex_ecall) begin
                    w_state_d = StHalt;
                end else if (hz.ex_enable_aes) begin
                    w_state_d = StAesWait;
                    w_cnt_d   = '0;
                end else if (w_load_use) begin
                    w_state_d = StRun;
                end else if (!hz.start_in) begin
                    w_state_d = StIdle;
                end
            end
            StAesWait: begin
                w_cnt_d = r_cnt + 1'b1;
                if (hz.aes_done) begin
                    w_state_d = StRun;
                end else if (w_timeout) begin
                    w_state_d   = StRun;
                    w_aes_err_d = 1'b1;
                end
            end
            StHalt: w_state_d = StHalt;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_flush     = 1'b0;
        w_start     = 1'b0;
        w_aes_start = 1'b0;
        w_wb_valid  = 1'b0;
        unique case (r_state)
            StIdle: w_flush = 1'b1;
            StRun: begin
                w_pc_en    = 1'b1;
                w_if_id_en = 1'b1;
                w_start    = 1'b1;
                // A load-use hit under a redirect is on the wrong path, so the redirect wins.
                if (w_redirect) begin
                    w_flush = 1'b1;
                    w_start = 1'b0;
                end else if (hz.ex_ecall) begin
                    w_pc_en    = 1'b0;
                    w_if_id_en = 1'b0;
                    w_start    = 1'b0;
                    w_flush    = 1'b1;
                end else if (hz.ex_enable_aes) begin
                    w_aes_start = 1'b1;
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_start     = 1'b0;
                end else if (w_load_use) begin
                    w_pc_en    = 1'b0;
                    w_if_id_en = 1'b0;
                    w_start    = 1'b0;
                end
            end
            StAesWait: begin
                if (hz.aes_done) begin
                    w_pc_en    = 1'b1;
                    w_if_id_en = 1'b1;
                    w_start    = 1'b1;
                    w_wb_valid = 1'b1;
                end
            end
            StHalt: w_flush = 1'b1;
            default: ;
        endcase
    end

    assign hz.pc_en        = reset_n & w_pc_en;
    assign hz.if_id_en     = reset_n & w_if_id_en;
    assign hz.if_id_flush  = reset_n & w_flush;
    assign hz.id_ex_start  = reset_n & w_start;
    assign hz.aes_start    = reset_n & w_aes_start;
    assign hz.aes_wb_valid = reset_n & w_wb_valid;
    assign hz.halted       = r_halted;
    assign hz.aes_err      = r_aes_err;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StRun || r_state == StAesWait) && !w_pc_en &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign hz.stall_cycles = r_stall_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RUN-state vector table plus AES, timeout, ECALL and reset
// sequences. Outputs are packed as {pc_en, if_id_en, if_id_flush, id_ex_start, aes_start, aes_wb_valid}.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   exp_stall;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.AES_TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] w_out;
    assign w_out = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_start, hz.aes_start,
                    hz.aes_wb_valid};

    localparam logic [5:0] OutRun   = 6'b110100;
    localparam logic [5:0] OutStall = 6'b000000;
    localparam logic [5:0] OutFlush = 6'b001000;
    localparam logic [5:0] OutRedir = 6'b111000;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mem_read;
        logic       br;
        logic       jal;
        logic       jalr;
        logic       done;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.id_rs1        = 5'd0;
        hz.id_rs2        = 5'd0;
        hz.id_use_rs1    = 1'b0;
        hz.id_use_rs2    = 1'b0;
        hz.ex_rd         = 5'd0;
        hz.ex_mem_read   = 1'b0;
        hz.ex_br_taken   = 1'b0;
        hz.ex_jal        = 1'b0;
        hz.ex_jalr       = 1'b0;
        hz.ex_ecall      = 1'b0;
        hz.ex_enable_aes = 1'b0;
        hz.aes_done      = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [5:0] exp);
        @(negedge clk);
        chk(name, {26'd0, w_out}, {26'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = 0;
        reset_n   = 1'b0;
        hz.start_in = 1'b0;
        clear_inputs();

        //           rs1    rs2    u1    u2    rd     mr    br    jal   jalr  done  exp
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutRun};
        vecs[1]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OutStall};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutRun};
        vecs[3]  = '{5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OutStall};
        vecs[4]  = '{5'd2, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OutRun};
        vecs[5]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OutRun};
        vecs[6]  = '{5'd9, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutRun};
        vecs[7]  = '{5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OutRedir};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OutRedir};
        vecs[9]  = '{5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, OutRedir};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, OutRun};

        // Under reset every control output is low and the status flags are clear.
        #2;
        chk("reset_outputs", {26'd0, w_out}, 32'd0);
        chk("reset_halted", {31'd0, hz.halted}, 32'd0);
        chk("reset_aes_err", {31'd0, hz.aes_err}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("idle_no_start", OutFlush);
        hz.start_in = 1'b1;
        cyc("idle_start", OutFlush);

        for (int i = 0; i < 11; i++) begin
            hz.id_rs1      = vecs[i].rs1;
            hz.id_rs2      = vecs[i].rs2;
            hz.id_use_rs1  = vecs[i].use1;
            hz.id_use_rs2  = vecs[i].use2;
            hz.ex_rd       = vecs[i].rd;
            hz.ex_mem_read = vecs[i].mem_read;
            hz.ex_br_taken = vecs[i].br;
            hz.ex_jal      = vecs[i].jal;
            hz.ex_jalr     = vecs[i].jalr;
            hz.aes_done    = vecs[i].done;
            if (vecs[i].exp[5] == 1'b0) exp_stall++;
            cyc($sformatf("vec%0d", i), vecs[i].exp);
        end
        clear_inputs();

        // start_in drop: current cycle still advances, then IDLE.
        hz.start_in = 1'b0;
        cyc("stop_advance", OutRun);
        hz.start_in = 1'b1;
        cyc("stop_idle", OutFlush);
        cyc("restart_run", OutRun);

        // AES launch, 5 wait cycles (start_in ignored), then done.
        hz.ex_enable_aes = 1'b1;
        cyc("aes_launch", 6'b000010);
        hz.ex_enable_aes = 1'b0;
        hz.start_in = 1'b0;
        for (int i = 0; i < 5; i++) cyc($sformatf("aes_wait%0d", i), OutStall);
        hz.start_in = 1'b1;
        hz.aes_done = 1'b1;
        cyc("aes_done", 6'b110101);
        hz.aes_done = 1'b0;
        exp_stall += 6;
        cyc("aes_back_run", OutRun);
        chk("aes_no_err", {31'd0, hz.aes_err}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt_aes", hz.stall_cycles, exp_stall);
`endif

        // AES timeout: 8 wait cycles with no done, error visible afterwards.
        hz.ex_enable_aes = 1'b1;
        cyc("to_launch", 6'b000010);
        hz.ex_enable_aes = 1'b0;
        for (int i = 0; i < 8; i++) cyc($sformatf("to_wait%0d", i), OutStall);
        exp_stall += 9;
        @(negedge clk);
        chk("to_aes_err", {31'd0, hz.aes_err}, 32'd1);
        hz.aes_done = 1'b1;
        #1;
        chk("to_late_done", {26'd0, w_out}, {26'd0, OutRun});
        @(posedge clk);
        #1;
        hz.aes_done = 1'b0;
        cyc("to_err_sticky_run", OutRun);
        chk("to_err_sticky", {31'd0, hz.aes_err}, 32'd1);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt_to", hz.stall_cycles, exp_stall);
`endif

        // ECALL: halted from the next cycle, terminal even under AES/redirect requests.
        hz.ex_ecall = 1'b1;
        @(negedge clk);
        chk("ecall_halted_pre", {31'd0, hz.halted}, 32'd0);
        cyc("ecall", OutFlush);
        hz.ex_ecall = 1'b0;
        hz.ex_enable_aes = 1'b1;
        hz.ex_jal = 1'b1;
        cyc("halt0", OutFlush);
        chk("halt_flag", {31'd0, hz.halted}, 32'd1);
        cyc("halt1", OutFlush);
        clear_inputs();

        // Asynchronous reset out of HALT, then IDLE -> RUN.
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst2_outputs", {26'd0, w_out}, 32'd0);
        chk("rst2_halted", {31'd0, hz.halted}, 32'd0);
        chk("rst2_aes_err", {31'd0, hz.aes_err}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("rst2_stall_cnt", hz.stall_cycles, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        hz.start_in = 1'b1;
        cyc("rst2_idle", OutFlush);
        cyc("rst2_run", OutRun);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
